lut3_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively exercises one 3-input combinational logic gate.
- The gate is any truth-table cell with inputs {in3,in2,in1} and a single output.
- Holds a programmable 8-bit expected truth table and, on start, drives all 8 input combinations in order. It waits a settle interval per vector, samples the gate output, and reports the observed table, a per-vector mismatch mask and a pass flag.
- Sits between the test/config host and the gate under characterization.

---
 rtl/lut3_sweep_ctrl_if.sv | 59 +++++
 rtl/lut3_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_lut3_sweep_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut3_sweep_ctrl_if.sv
// Interface between the host, the sweep controller and the gate under characterization.
// Host side: configuration, control and results. Gate side: the three drive bits and the
// gate's output.
interface lut3_sweep_ctrl_if;
  // Host configuration handshake
  logic       cfg_valid;
  logic [7:0] cfg_table;
  logic       cfg_ready;
  // Sweep control
  logic       start;
  logic       abort;
  logic       busy;
  // Gate under characterization
  logic       dut_in1;
  logic       dut_in2;
  logic       dut_in3;
  logic       dut_out;
  // Results
  logic       done;
  logic       pass;
  logic [7:0] obs_table;
  logic [7:0] mismatch;

  // Controller side
  modport slave (
    input  cfg_valid,
    input  cfg_table,
    input  start,
    input  abort,
    input  dut_out,
    output cfg_ready,
    output busy,
    output dut_in1,
    output dut_in2,
    output dut_in3,
    output done,
    output pass,
    output obs_table,
    output mismatch
  );

  // Host / gate side
  modport master (
    output cfg_valid,
    output cfg_table,
    output start,
    output abort,
    output dut_out,
    input  cfg_ready,
    input  busy,
    input  dut_in1,
    input  dut_in2,
    input  dut_in3,
    input  done,
    input  pass,
    input  obs_table,
    input  mismatch
  );
endinterface

// File: rtl/lut3_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 3-input truth-table cell. Drives vectors 0..7 in order,
// waits SETTLE_CYCLES per vector, samples the gate output, and reports the observed table,
// a per-vector mismatch mask against the expected table and a pass flag.
module lut3_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  RESET_TABLE   = 8'h97
) (
  input  logic              clk,
  input  logic              rst,
  lut3_sweep_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] exp_q, exp_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] obs_q, obs_d;
  logic [7:0] mm_q, mm_d;

  // Next-state and registered-output decode for the sweep FSM
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    obs_d   = obs_q;
    mm_d    = mm_q;

    unique case (state_q)
      StIdle: begin
        // Table load lands on the same edge as start, so the new table governs this sweep
        if (bus.cfg_valid) begin
          exp_d = bus.cfg_table;
        end
        if (bus.start && !bus.abort) begin
          state_d = StDrive;
          idx_d   = 3'd0;
          obs_d   = 8'h00;
          mm_d    = 8'h00;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StDrive: begin
        vec_d = idx_q;
        if (SETTLE_CYCLES == 0) begin
          state_d = StSample;
        end else begin
          cnt_d   = 8'(SETTLE_CYCLES - 1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSample: begin
        obs_d[idx_q] = bus.dut_out;
        if (idx_q == 3'd7) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        mm_d    = obs_q ^ exp_q;
        pass_d  = (obs_q == exp_q);
        vec_d   = 3'd0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything while busy; the partial observed table is kept
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      vec_d   = 3'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      mm_d    = 8'h00;
      obs_d   = obs_q;
      idx_d   = 3'd0;
      cnt_d   = 8'd0;
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      exp_q   <= RESET_TABLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      vec_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      obs_q   <= 8'h00;
      mm_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      obs_q   <= obs_d;
      mm_q    <= mm_d;
    end
  end

  // cfg_ready is the only state-decoded output; it drops as soon as reset is applied
  assign bus.cfg_ready = (state_q == StIdle) && !rst;
  assign bus.busy      = busy_q;
  assign bus.dut_in1   = vec_q[0];
  assign bus.dut_in2   = vec_q[1];
  assign bus.dut_in3   = vec_q[2];
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.obs_table = obs_q;
  assign bus.mismatch  = mm_q;

endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
// Scoreboard bench for lut3_sweep_ctrl: two instances (settle 2 and settle 0) driven with
// directed vectors; expected results are queued at start and checked on each done pulse.
module tb_lut3_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] gate_f;

  always #5 clk = ~clk;

  lut3_sweep_ctrl_if bus0 ();
  lut3_sweep_ctrl_if bus1 ();

  lut3_sweep_ctrl #(.SETTLE_CYCLES(2), .RESET_TABLE(8'h97)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  lut3_sweep_ctrl #(.SETTLE_CYCLES(0), .RESET_TABLE(8'h97)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Behavioural gate model: output is bit {in3,in2,in1} of gate_f
  logic [2:0] vec0, vec1;
  assign vec0 = {bus0.dut_in3, bus0.dut_in2, bus0.dut_in1};
  assign vec1 = {bus1.dut_in3, bus1.dut_in2, bus1.dut_in1};
  assign bus0.dut_out = gate_f[vec0];
  assign bus1.dut_out = gate_f[vec1];

  typedef struct {
    logic [7:0] obs;
    logic [7:0] mm;
    logic       pass;
    int         start_cyc;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt0 = 0;
  int   vec_log[$];
  logic [2:0] prev_vec0 = 3'd0;
  bit   log_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor for dut0: compares each done pulse against the head of its queue
  always @(negedge clk) begin
    if (bus0.done === 1'b1) begin
      done_cnt0 <= done_cnt0 + 1;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_done: got done=1 want no done");
      end else begin
        e0 = q0.pop_front();
        chk("dut0_obs", bus0.obs_table, e0.obs);
        chk("dut0_mismatch", bus0.mismatch, e0.mm);
        chk("dut0_pass", bus0.pass, e0.pass);
        chk("dut0_latency", cyc - e0.start_cyc, e0.lat);
      end
    end
  end

  // Monitor for dut1
  always @(negedge clk) begin
    if (bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_done: got done=1 want no done");
      end else begin
        e1 = q1.pop_front();
        chk("dut1_obs", bus1.obs_table, e1.obs);
        chk("dut1_mismatch", bus1.mismatch, e1.mm);
        chk("dut1_pass", bus1.pass, e1.pass);
        chk("dut1_latency", cyc - e1.start_cyc, e1.lat);
      end
    end
  end

  // Records every change of dut0's drive vector while enabled
  always @(negedge clk) begin
    if (log_en && (vec0 != prev_vec0)) vec_log.push_back(int'(vec0));
    prev_vec0 <= vec0;
  end

  // Called at a negedge; pulses start for one cycle and optionally queues the expected result
  task automatic start_sweep(input int which, input bit push, input logic [7:0] obs,
                             input logic [7:0] mm, input logic pass);
    exp_t e;
    e.obs       = obs;
    e.mm        = mm;
    e.pass      = pass;
    e.start_cyc = cyc + 1;
    if (which == 0) begin
      e.lat = 33;
      bus0.start = 1'b1;
      if (push) q0.push_back(e);
    end else begin
      e.lat = 17;
      bus1.start = 1'b1;
      if (push) q1.push_back(e);
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // Bounded wait for the scoreboard queue of one instance to drain
  task automatic wait_done(input int which);
    for (int i = 0; i < 200; i++) begin
      if (((which == 0) ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    if (((which == 0) ? q0.size() : q1.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_done_timeout: got no done want done within 200 cycles", which);
      if (which == 0) q0.delete();
      else q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base_done;
    rst            = 1'b1;
    gate_f         = 8'h97;
    bus0.cfg_valid = 1'b0;
    bus0.cfg_table = 8'h00;
    bus0.start     = 1'b0;
    bus0.abort     = 1'b0;
    bus1.cfg_valid = 1'b0;
    bus1.cfg_table = 8'h00;
    bus1.start     = 1'b0;
    bus1.abort     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", bus0.cfg_ready, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_obs", bus0.obs_table, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cfg_ready", bus0.cfg_ready, 1);
    chk("idle_busy", bus0.busy, 0);
    chk("idle_pass", bus0.pass, 0);
    chk("idle_mismatch", bus0.mismatch, 8'h00);
    chk("idle_dut_in", vec0, 3'd0);

    // Default table, gate 0x97
    vec_log.delete();
    log_en = 1'b1;
    start_sweep(0, 1'b1, 8'h97, 8'h00, 1'b1);
    chk("sweep_busy", bus0.busy, 1);
    chk("sweep_cfg_ready", bus0.cfg_ready, 0);
    wait_done(0);
    log_en = 1'b0;
    chk("vec_log_len", vec_log.size(), 8);
    for (int i = 0; i < 8 && i < vec_log.size(); i++) begin
      chk($sformatf("vec_order_%0d", i), vec_log[i], (i + 1) % 8);
    end
    chk("pass_held", bus0.pass, 1);
    chk("done_one_cycle", bus0.done, 0);

    // AND3 expected table against gate 0x97
    bus0.cfg_valid = 1'b1;
    bus0.cfg_table = 8'h80;
    chk("cfg_ready_load", bus0.cfg_ready, 1);
    @(negedge clk);
    bus0.cfg_valid = 1'b0;
    start_sweep(0, 1'b1, 8'h97, 8'h17, 1'b0);
    wait_done(0);

    // Table load in the start cycle; mid-sweep load ignored
    bus0.cfg_valid = 1'b1;
    bus0.cfg_table = 8'hFE;
    start_sweep(0, 1'b1, 8'h97, 8'h69, 1'b0);
    bus0.cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus0.cfg_valid = 1'b1;
    bus0.cfg_table = 8'h00;
    chk("cfg_ready_busy", bus0.cfg_ready, 0);
    @(negedge clk);
    bus0.cfg_valid = 1'b0;
    wait_done(0);
    gate_f = 8'hFE;
    start_sweep(0, 1'b1, 8'hFE, 8'h00, 1'b1);
    wait_done(0);

    // abort and start together in IDLE: nothing happens
    bus0.abort = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    bus0.start = 1'b0;
    chk("abort_start_busy", bus0.busy, 0);
    chk("abort_idle_pass", bus0.pass, 1);
    repeat (2) @(negedge clk);
    chk("abort_start_still_idle", bus0.busy, 0);

    // Abort during vector 4 settle, with a stray start at vector 2
    gate_f    = 8'h5A;
    base_done = done_cnt0;
    start_sweep(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (7) @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", bus0.busy, 1);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    chk("abort_busy", bus0.busy, 0);
    chk("abort_done", bus0.done, 0);
    chk("abort_pass", bus0.pass, 0);
    chk("abort_mismatch", bus0.mismatch, 8'h00);
    chk("abort_obs_partial", bus0.obs_table, 8'h0A);
    chk("abort_dut_in", vec0, 3'd0);
    chk("abort_cfg_ready", bus0.cfg_ready, 1);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt0, base_done);

    // Reset mid-sweep
    gate_f = 8'h97;
    start_sweep(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_obs", bus0.obs_table, 8'h00);
    chk("midrst_dut_in", vec0, 3'd0);
    chk("midrst_cfg_ready", bus0.cfg_ready, 0);
    chk("midrst_pass", bus0.pass, 0);
    chk("midrst_done", bus0.done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_sweep(0, 1'b1, 8'h97, 8'h00, 1'b1);
    wait_done(0);

    // Zero settle instance
    gate_f = 8'h97;
    start_sweep(1, 1'b1, 8'h97, 8'h00, 1'b1);
    wait_done(1);
    gate_f = 8'h3C;
    bus1.cfg_valid = 1'b1;
    bus1.cfg_table = 8'h3C;
    @(negedge clk);
    bus1.cfg_valid = 1'b0;
    start_sweep(1, 1'b1, 8'h3C, 8'h00, 1'b1);
    wait_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
